// File: rtl/act_lut_loader.sv
// act_lut_loader: streams a 2^AW-entry activation table into on-chip storage and serves a dual-address registered read port.
// Optional ACT_LUT_CSUM_EN adds a trailing checksum beat verified against the sum of table words mod 2^DW.
module act_lut_loader #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    input  logic          s_last,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   count,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data_a,
    output logic [DW-1:0] rd_data_b
);
    localparam int DEPTH = 2 ** AW;
    localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, DRAIN = 2'd2;

    logic [1:0]    state;
    logic [DW-1:0] mem [DEPTH];
    logic          accept, table_word, last_word, we;
    logic [AW-1:0] rd_next;

    assign s_ready    = state != IDLE;
    assign busy       = state != IDLE;
    assign accept     = s_valid & s_ready;
    assign table_word = !count[AW];
    assign last_word  = count == (AW+1)'(DEPTH - 1);
    assign we         = state == LOAD && accept && table_word;
    assign rd_next    = rd_addr + 1'b1;

    always_ff @(posedge clk) begin
        if (we) mem[count[AW-1:0]] <= s_data;
    end

    // Nonblocking write above gives read-before-write on same-address collisions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else begin
            rd_data_a <= mem[rd_addr];
            rd_data_b <= mem[rd_next];
        end
    end

`ifdef ACT_LUT_CSUM_EN
    logic [DW-1:0] acc;
    logic          csum_ok;
    assign csum_ok = acc == s_data;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc <= '0;
        else if (state == IDLE && start) acc <= '0;
        else if (we) acc <= acc + s_data;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            done  <= 1'b0;
            err   <= 1'b0;
            count <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= LOAD;
                    done  <= 1'b0;
                    err   <= 1'b0;
                    count <= '0;
                end
                LOAD: if (accept) begin
                    if (table_word) begin
                        count <= count + 1'b1;
`ifdef ACT_LUT_CSUM_EN
                        if (s_last) begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end
`else
                        if (s_last) begin
                            done  <= last_word;
                            err   <= !last_word;
                            state <= IDLE;
                        end else if (last_word) begin
                            err   <= 1'b1;
                            state <= DRAIN;
                        end
`endif
                    end
`ifdef ACT_LUT_CSUM_EN
                    else begin
                        done  <= s_last && csum_ok;
                        err   <= !(s_last && csum_ok);
                        state <= s_last ? IDLE : DRAIN;
                    end
`endif
                end
                DRAIN: if (accept && s_last) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_act_lut_loader.sv
// tb_act_lut_loader: randomized frame-level checks of act_lut_loader against a table/outcome model.
// Works with or without ACT_LUT_CSUM_EN defined.
module tb_act_lut_loader;
    localparam int AW = 10, DW = 16, DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst_n, start, s_valid, s_ready, s_last, busy, done, err;
    logic [DW-1:0] s_data, rd_data_a, rd_data_b;
    logic [AW:0]   count;
    logic [AW-1:0] rd_addr;

    int checks = 0, errors = 0;
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] fq [$];
    logic          exp_done, exp_err;
    int            exp_count, n_acc;

    act_lut_loader #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .busy(busy), .done(done), .err(err),
        .count(count), .rd_addr(rd_addr), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b)
    );

    always #5 clk = ~clk;

    task automatic build_frame(input int n, input int kind);
        fq.delete();
        for (int i = 0; i < n; i++)
            fq.push_back(kind == 0 ? DW'(i) : kind == 1 ? DW'($urandom) : kind == 2 ? DW'(1) : DW'(i + 16'h4000));
    endtask

    task automatic add_checksum(input logic [DW-1:0] delta);
        logic [DW-1:0] s = '0;
        for (int i = 0; i < DEPTH; i++) s += fq[i];
        fq.push_back(s + delta);
    endtask

    task automatic finish_frame();
`ifdef ACT_LUT_CSUM_EN
        add_checksum('0);
`endif
    endtask

    // Frame-level outcome: which words land in the table and the final status.
    task automatic model();
        int n = fq.size();
        logic [DW-1:0] s = '0;
        exp_count = n < DEPTH ? n : DEPTH;
        for (int i = 0; i < exp_count; i++) begin
            ref_mem[i] = fq[i];
            s += fq[i];
        end
`ifdef ACT_LUT_CSUM_EN
        exp_done = (n == DEPTH + 1) && (fq[DEPTH] == s);
`else
        exp_done = (n == DEPTH);
`endif
        exp_err = !exp_done;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive_frame(input bit gaps, input int start_at, input int abort_at);
        n_acc = 0;
        for (int i = 0; i < fq.size(); i++) begin
            int t = 0;
            if (i == abort_at) begin
                rst_n = 1'b0;
                s_valid = 1'b0;
                return;
            end
            if (gaps) repeat ($urandom_range(0, 2)) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
            s_valid = 1'b1;
            s_data  = fq[i];
            s_last  = (i == fq.size() - 1);
            start   = (i == start_at);
            while (!s_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (!s_ready) begin
                checks++;
                errors++;
                $display("FAIL handshake_timeout beat=%0d s_ready=%0b required=1", i, s_ready);
                s_valid = 1'b0;
                start = 1'b0;
                return;
            end
            @(negedge clk);
            start = 1'b0;
            n_acc++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic do_read(input int a);
        rd_addr = AW'(a);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({s_ready, busy, done, err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b required=0000", {s_ready, busy, done, err});
        end
        checks++;
        if ({count, rd_data_a, rd_data_b} !== '0) begin
            errors++;
            $display("FAIL reset_data count=%0d a=%h b=%h required=0", count, rd_data_a, rd_data_b);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_load();
        build_frame(DEPTH, 0);
        finish_frame();
        pulse_start();
        checks++;
        if ({s_ready, busy, done, err} !== 4'b1100) begin
            errors++;
            $display("FAIL start_to_load got=%b required=1100", {s_ready, busy, done, err});
        end
        drive_frame(1'b0, -1, -1);
        model();
        checks++;
        if ({done, err, busy} !== {exp_done, exp_err, 1'b0} || count !== (AW+1)'(exp_count)) begin
            errors++;
            $display("FAIL full_status done=%b err=%b busy=%b count=%0d required %b %b 0 %0d",
                     done, err, busy, count, exp_done, exp_err, exp_count);
        end
        foreach (fq[i]) if (i == 0) begin end
        for (int k = 0; k < 10; k++) begin
            int a = k == 0 ? 5 : k == 1 ? DEPTH - 1 : int'($urandom_range(0, DEPTH - 1));
            do_read(a);
            checks++;
            if (rd_data_a !== ref_mem[a] || rd_data_b !== ref_mem[(a + 1) % DEPTH]) begin
                errors++;
                $display("FAIL full_read addr=%0d a=%h b=%h required %h %h",
                         a, rd_data_a, rd_data_b, ref_mem[a], ref_mem[(a + 1) % DEPTH]);
            end
        end
    endtask

    task automatic test_short_frame();
        build_frame(100, 3);
        pulse_start();
        drive_frame(1'b0, -1, -1);
        model();
        checks++;
        if ({done, err, busy} !== {exp_done, exp_err, 1'b0} || count !== (AW+1)'(exp_count)) begin
            errors++;
            $display("FAIL short_status done=%b err=%b busy=%b count=%0d required %b %b 0 %0d",
                     done, err, busy, count, exp_done, exp_err, exp_count);
        end
        for (int k = 0; k < 3; k++) begin
            int a = k == 0 ? 99 : k == 1 ? 100 : 0;
            do_read(a);
            checks++;
            if (rd_data_a !== ref_mem[a] || rd_data_b !== ref_mem[(a + 1) % DEPTH]) begin
                errors++;
                $display("FAIL short_read addr=%0d a=%h b=%h required %h %h",
                         a, rd_data_a, rd_data_b, ref_mem[a], ref_mem[(a + 1) % DEPTH]);
            end
        end
    endtask

    task automatic test_long_frame();
        build_frame(DEPTH + 6, 1);
        pulse_start();
        drive_frame(1'b0, -1, -1);
        model();
        checks++;
        if ({done, err, busy} !== {exp_done, exp_err, 1'b0} || count !== (AW+1)'(exp_count)) begin
            errors++;
            $display("FAIL long_status done=%b err=%b busy=%b count=%0d required %b %b 0 %0d",
                     done, err, busy, count, exp_done, exp_err, exp_count);
        end
        for (int k = 0; k < 4; k++) begin
            int a = k == 0 ? 0 : k == 1 ? DEPTH - 1 : int'($urandom_range(0, DEPTH - 1));
            do_read(a);
            checks++;
            if (rd_data_a !== ref_mem[a] || rd_data_b !== ref_mem[(a + 1) % DEPTH]) begin
                errors++;
                $display("FAIL long_read addr=%0d a=%h b=%h required %h %h",
                         a, rd_data_a, rd_data_b, ref_mem[a], ref_mem[(a + 1) % DEPTH]);
            end
        end
    endtask

`ifdef ACT_LUT_CSUM_EN
    task automatic test_checksum();
        for (int k = 0; k < 2; k++) begin
            build_frame(DEPTH, 2);
            add_checksum(DW'(k));
            pulse_start();
            drive_frame(1'b0, -1, -1);
            model();
            checks++;
            if ({done, err} !== {exp_done, exp_err} || count !== (AW+1)'(exp_count)) begin
                errors++;
                $display("FAIL csum_%0d done=%b err=%b count=%0d required %b %b %0d",
                         k, done, err, count, exp_done, exp_err, exp_count);
            end
        end
    endtask
`endif

    task automatic test_gaps_restart();
        build_frame(DEPTH, 1);
        finish_frame();
        pulse_start();
        drive_frame(1'b1, 200, 500);
        for (int i = 0; i < n_acc; i++) ref_mem[i] = fq[i];
        #1;
        checks++;
        if ({s_ready, busy, done, err} !== 4'b0 || count !== '0 || {rd_data_a, rd_data_b} !== '0) begin
            errors++;
            $display("FAIL midload_reset flags=%b count=%0d a=%h b=%h required 0",
                     {s_ready, busy, done, err}, count, rd_data_a, rd_data_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_read(250);
        checks++;
        if (rd_data_a !== ref_mem[250]) begin
            errors++;
            $display("FAIL partial_keep a=%h required %h", rd_data_a, ref_mem[250]);
        end
        build_frame(DEPTH, 1);
        finish_frame();
        pulse_start();
        drive_frame(1'b1, 300, -1);
        model();
        checks++;
        if ({done, err, busy} !== {exp_done, exp_err, 1'b0} || count !== (AW+1)'(exp_count)) begin
            errors++;
            $display("FAIL reload_status done=%b err=%b busy=%b count=%0d required %b %b 0 %0d",
                     done, err, busy, count, exp_done, exp_err, exp_count);
        end
        for (int k = 0; k < 6; k++) begin
            int a = $urandom_range(0, DEPTH - 1);
            do_read(a);
            checks++;
            if (rd_data_a !== ref_mem[a] || rd_data_b !== ref_mem[(a + 1) % DEPTH]) begin
                errors++;
                $display("FAIL reload_read addr=%0d a=%h b=%h required %h %h",
                         a, rd_data_a, rd_data_b, ref_mem[a], ref_mem[(a + 1) % DEPTH]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; rd_addr = '0;
        @(negedge clk);
        test_reset();
        test_full_load();
        test_short_frame();
        test_long_frame();
`ifdef ACT_LUT_CSUM_EN
        test_checksum();
`endif
        test_gaps_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
